// File: rtl/wifi_tx_mapper_multimode.sv
// Bit-serial BPSK/QPSK/16QAM/64QAM mapper with valid/ready output.
// Define WIFI_TX_MAPPER_SYM_CNT_EN to enable the delivered-symbol counter.
module wifi_tx_mapper_multimode #(
  parameter int DW        = 12,
  parameter int SYM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 bit_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        data_out_real,
  output logic [DW-1:0]        data_out_imag,
  output logic [SYM_CNT_W-1:0] sym_count
);

  localparam int SH = DW - 12;
  localparam logic [DW-1:0] A_M  = DW'(512 << SH);
  localparam logic [DW-1:0] Q_M  = DW'(362 << SH);
  localparam logic [DW-1:0] S1_M = DW'(162 << SH);
  localparam logic [DW-1:0] S3_M = DW'(486 << SH);
  localparam logic [DW-1:0] E1_M = DW'(79 << SH);
  localparam logic [DW-1:0] E3_M = DW'(237 << SH);
  localparam logic [DW-1:0] E5_M = DW'(395 << SH);
  localparam logic [DW-1:0] E7_M = DW'(553 << SH);

  logic [2:0]    count_q, count_d;
  logic [4:0]    sr_q, sr_d;
  logic [1:0]    mode_q;
  logic          valid_q;
  logic [DW-1:0] re_q, im_q;
  logic [DW-1:0] re_d, im_d;
  logic [1:0]    eff_mode;
  logic [2:0]    last;
  logic [5:0]    w;
  logic          accept, load, deliver, first;

  function automatic logic [DW-1:0] sgn(
    input logic pos, input logic [DW-1:0] m);
    return pos ? m : DW'(0) - m;
  endfunction

  // Gray-coded magnitude from the two low-order bits of a 64QAM axis
  function automatic logic [DW-1:0] mag64(input logic [1:0] b);
    logic [DW-1:0] m;
    unique case (b)
      2'b00:   m = E7_M;
      2'b01:   m = E5_M;
      2'b11:   m = E3_M;
      default: m = E1_M;
    endcase
    return m;
  endfunction

  assign bit_ready = !(valid_q && !out_ready);
  assign accept    = bit_valid && bit_ready;
  assign deliver   = valid_q && out_ready;
  assign first     = (count_q == 3'd0);
  assign eff_mode  = first ? mode : mode_q;
  assign w         = {sr_q, bit_in};
  assign load      = accept && !flush && (count_q == last);

  // Current bit is the newest sample, so b0 sits at w[N-1]
  always_comb begin
    last = 3'd0;
    re_d = '0;
    im_d = '0;
    unique case (eff_mode)
      2'b00: begin
        last = 3'd0;
        re_d = sgn(w[0], A_M);
      end
      2'b01: begin
        last = 3'd1;
        re_d = sgn(w[1], Q_M);
        im_d = sgn(w[0], Q_M);
      end
      2'b10: begin
        last = 3'd3;
        re_d = sgn(w[3], w[2] ? S1_M : S3_M);
        im_d = sgn(w[1], w[0] ? S1_M : S3_M);
      end
      default: begin
        last = 3'd5;
        re_d = sgn(w[5], mag64(w[4:3]));
        im_d = sgn(w[2], mag64(w[1:0]));
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    sr_d    = sr_q;
    if (flush) begin
      count_d = 3'd0;
      sr_d    = '0;
    end else if (accept) begin
      sr_d    = w[4:0];
      count_d = load ? 3'd0 : count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 3'd0;
      sr_q    <= '0;
      mode_q  <= 2'b00;
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      count_q <= count_d;
      sr_q    <= sr_d;
      if (accept && !flush && first)
        mode_q <= mode;
      if (load) begin
        valid_q <= 1'b1;
        re_q    <= re_d;
        im_q    <= im_d;
      end else if (deliver) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_q;
  assign data_out_real = re_q;
  assign data_out_imag = im_q;

`ifdef WIFI_TX_MAPPER_SYM_CNT_EN
  logic [SYM_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (deliver)
      cnt_q <= cnt_q + 1'b1;
  end

  assign sym_count = cnt_q;
`else
  assign sym_count = '0;
`endif

endmodule

// File: tb/tb_wifi_tx_mapper_multimode.sv
// Directed-vector bench for wifi_tx_mapper_multimode at DW=12.
module tb_wifi_tx_mapper_multimode;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] data_out_real;
  logic [11:0] data_out_imag;
  logic [15:0] sym_count;

  int checks = 0;
  int errors = 0;

  wifi_tx_mapper_multimode #(.DW(12), .SYM_CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .bit_valid(bit_valid),
    .bit_in(bit_in),
    .bit_ready(bit_ready),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out_real(data_out_real),
    .data_out_imag(data_out_imag),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    checks++;
    if (data_out_real !== 12'h000 || data_out_imag !== 12'h000) begin
      errors++;
      $display("FAIL rst_data got %h/%h want 000/000",
               data_out_real, data_out_imag);
    end
    checks++;
    if (sym_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d want 0", sym_count);
    end
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", bit_ready);
    end
    idle();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_bpsk();
    mode = 2'b00;
    push(1'b0);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'hE00 ||
        data_out_imag !== 12'h000) begin
      errors++;
      $display("FAIL bpsk0 got v=%b %h/%h want 1 E00/000",
               out_valid, data_out_real, data_out_imag);
    end
    push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h200 ||
        data_out_imag !== 12'h000) begin
      errors++;
      $display("FAIL bpsk1 got v=%b %h/%h want 1 200/000",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
  endtask

  task automatic test_qpsk();
    mode = 2'b01;
    push(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL qpsk_mid got v=%b want 0", out_valid);
    end
    push(1'b0);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h16A ||
        data_out_imag !== 12'hE96) begin
      errors++;
      $display("FAIL qpsk got v=%b %h/%h want 1 16A/E96",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0 || data_out_real !== 12'h16A) begin
      errors++;
      $display("FAIL qpsk_once got v=%b %h want 0 16A",
               out_valid, data_out_real);
    end
  endtask

  task automatic test_16qam();
    mode = 2'b10;
    push(1'b1); push(1'b0); push(1'b1); push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h1E6 ||
        data_out_imag !== 12'h0A2) begin
      errors++;
      $display("FAIL qam16_a got v=%b %h/%h want 1 1E6/0A2",
               out_valid, data_out_real, data_out_imag);
    end
    push(1'b0); push(1'b0); push(1'b0); push(1'b0);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'hE1A ||
        data_out_imag !== 12'hE1A) begin
      errors++;
      $display("FAIL qam16_b got v=%b %h/%h want 1 E1A/E1A",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
  endtask

  task automatic test_64qam();
    mode = 2'b11;
    push(1'b1); push(1'b0); push(1'b0);
    mode = 2'b00;
    push(1'b0); push(1'b1); push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h229 ||
        data_out_imag !== 12'hF13) begin
      errors++;
      $display("FAIL qam64 got v=%b %h/%h want 1 229/F13",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_re;
    logic [2:0]  pat;
    pat  = 3'b101;
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push(pat[i]);
      exp_re = pat[i] ? 12'h200 : 12'hE00;
      checks++;
      if (out_valid !== 1'b1 || data_out_real !== exp_re) begin
        errors++;
        $display("FAIL b2b[%0d] got v=%b %h want 1 %h",
                 i, out_valid, data_out_real, exp_re);
      end
    end
    idle();
  endtask

  task automatic test_stall();
    logic [15:0] exp_cnt;
    do_reset();
    out_ready = 1'b0;
    mode      = 2'b00;
    push(1'b1);
    mode      = 2'b10;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    idle(); idle(); idle();
    checks++;
    if (bit_ready !== 1'b0 || out_valid !== 1'b1 ||
        data_out_real !== 12'h200) begin
      errors++;
      $display("FAIL stall_hold got rdy=%b v=%b %h want 0 1 200",
               bit_ready, out_valid, data_out_real);
    end
    out_ready = 1'b1;
    idle();
    bit_valid = 1'b0;
`ifdef WIFI_TX_MAPPER_SYM_CNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (out_valid !== 1'b0 || sym_count !== exp_cnt) begin
      errors++;
      $display("FAIL stall_rel got v=%b cnt=%0d want 0 %0d",
               out_valid, sym_count, exp_cnt);
    end
    push(1'b0); push(1'b1); push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h1E6 ||
        data_out_imag !== 12'h0A2) begin
      errors++;
      $display("FAIL stall_next got v=%b %h/%h want 1 1E6/0A2",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
`ifdef WIFI_TX_MAPPER_SYM_CNT_EN
    exp_cnt = 16'd2;
`endif
    checks++;
    if (sym_count !== exp_cnt) begin
      errors++;
      $display("FAIL stall_cnt got %0d want %0d", sym_count, exp_cnt);
    end
  endtask

  task automatic test_flush();
    mode = 2'b10;
    push(1'b0); push(1'b0);
    flush = 1'b1;
    push(1'b0);
    flush = 1'b0;
    push(1'b1); push(1'b1); push(1'b1); push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h0A2 ||
        data_out_imag !== 12'h0A2) begin
      errors++;
      $display("FAIL flush_sym got v=%b %h/%h want 1 0A2/0A2",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
    out_ready = 1'b0;
    mode      = 2'b00;
    push(1'b0);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'hE00) begin
      errors++;
      $display("FAIL flush_pend got v=%b %h want 1 E00",
               out_valid, data_out_real);
    end
    out_ready = 1'b1;
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    mode      = 2'b01;
    push(1'b1); push(1'b1);
    reset = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || data_out_real !== 12'h000 ||
        data_out_imag !== 12'h000 || sym_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_pend got v=%b %h/%h cnt=%0d want 0 000/000 0",
               out_valid, data_out_real, data_out_imag, sym_count);
    end
    idle();
    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    mode = 2'b10;
    push(1'b1);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    idle();
    mode = 2'b00;
    push(1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out_real !== 12'h200 ||
        data_out_imag !== 12'h000) begin
      errors++;
      $display("FAIL rst_partial got v=%b %h/%h want 1 200/000",
               out_valid, data_out_real, data_out_imag);
    end
    idle();
  endtask

  initial begin
    reset     = 1'b0;
    mode      = 2'b00;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_16qam();
    test_64qam();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
